sr_drive_ctrl: RTL
==================

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive cycles a synchronized button must differ from its debounced value before that value toggles; legal range 2..255.
REQ-002 Parameter PULSE_LEN, default 1: number of cycles s or r is driven per command; legal range 1..15.
REQ-003 Parameter CNT_W, default 8: width of cmd_cnt.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low: reset==0 at a rising clk edge resets the block.
REQ-006 set_btn  input  1  raw asynchronous set request from a pushbutton.
REQ-007 rst_btn  input  1  raw asynchronous reset request from a pushbutton.
REQ-008 q_fb  input  1  q output of the downstream SR flip-flop, used for command checking.
REQ-009 s  output  1  registered set drive to the downstream SR flip-flop.
REQ-010 r  output  1  registered reset drive to the downstream SR flip-flop.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 err  output  1  sticky flag: a completed command was not reflected on q_fb.
REQ-013 cmd_cnt  output  CNT_W  count of completed commands; wraps modulo 2^CNT_W.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-015 Debounce, per button: counter increments on each edge where the synchronized value differs from the debounced value; a match clears the counter; on the edge where counter==DEB_CYCLES-1 with a mismatch, the debounced value toggles and the counter clears.
REQ-016 A 0->1 transition of a debounced value SHALL set that button's pending flag on the next edge; a 1->0 transition SHALL generate nothing.
REQ-017 A request arriving while its own pending flag is already set SHALL merge into it; it is neither queued nor counted.
REQ-018 FSM states are IDLE, DRIVE and CHECK.
REQ-019 IDLE -> DRIVE when any pending flag is set; that flag clears on the same edge.
REQ-020 If both flags are pending in IDLE, reset wins; the set flag stays pending and executes after the FSM returns to IDLE.
REQ-021 DRIVE lasts exactly PULSE_LEN cycles: s=1,r=0 for a set command, or s=0,r=1 for a reset command; DRIVE -> CHECK after the last cycle.
REQ-022 CHECK lasts one cycle with s=r=0.
REQ-023 In CHECK, q_fb is compared with the expected value (1 for set, 0 for reset); a mismatch sets err.
REQ-024 On leaving CHECK, cmd_cnt increments, wrapping from 2^CNT_W-1 to 0, and the FSM returns to IDLE.
REQ-025 Invariant: s and r are never both 1 in any cycle, under any input or reset sequence.
REQ-026 Outside DRIVE, s=r=0.
REQ-027 Button activity during DRIVE or CHECK only updates debounce state and pending flags; it never alters the command in flight.
REQ-028 err is cleared only by reset.

Reset
REQ-029 When reset==0 at a rising edge, all of the following SHALL clear: synchronizers, debounced values, debounce counters, pending flags, FSM (to IDLE), s, r, busy, err and cmd_cnt.
REQ-030 Reset asserted mid-DRIVE SHALL force s=r=0 from that edge on; the aborted command does not increment cmd_cnt.
REQ-031 After reset is released, the first possible DRIVE is the 7th edge after a button is first sampled high.

Verification (DEB_CYCLES=4, PULSE_LEN=2)
REQ-032 Hold set_btn=1 from sampling edge N, with q_fb following s -> s=1 after edges N+7 and N+8, CHECK after N+9, busy=0 after N+10, cmd_cnt=1, err=0.
REQ-033 Glitch rst_btn=1 for 3 cycles, then return it to 0 -> no command issued; s=r=0; cmd_cnt unchanged.
REQ-034 Assert set_btn and rst_btn on the same edge -> reset command first (r=1 for 2 cycles), then set command (s=1 for 2 cycles); cmd_cnt=2; s&r never 1.
REQ-035 Tie q_fb=0 and issue a set command -> err=1 after CHECK and stays 1 through further commands until reset==0.
REQ-036 Drive reset=0 during the first DRIVE cycle -> s=0 at the next edge; busy=0; cmd_cnt=0; no later command without a new button press.
REQ-037 Issue 256 commands with CNT_W=8 -> cmd_cnt wraps from 255 to 0.

Source files
------------

// File: rtl/sr_drive_ctrl.sv
// Pushbutton front end for a downstream SR flip-flop: synchronizes and debounces two buttons,
// then issues one-at-a-time set/reset pulses and checks the flop's response on q_fb.
module sr_drive_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int PULSE_LEN  = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_btn,
  input  logic             rst_btn,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cmd_cnt
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [7:0] DEB_LAST   = 8'(DEB_CYCLES - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);

  // Bit 0 carries the set button, bit 1 the reset button.
  logic [1:0]       r_sync1, r_sync2, r_deb, r_deb_d, r_pend;
  logic [7:0]       r_dcnt [2];
  state_t           r_state;
  logic             r_cmd_rst;
  logic [3:0]       r_pcnt;
  logic             r_s, r_r, r_busy, r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_rise;
  logic             w_take_rst, w_take_set;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_deb     <= '0;
      r_deb_d   <= '0;
      r_dcnt[0] <= '0;
      r_dcnt[1] <= '0;
    end else begin
      r_sync1 <= {rst_btn, set_btn};
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_deb[b]) begin
          r_dcnt[b] <= '0;
        end else if (r_dcnt[b] == DEB_LAST) begin
          r_deb[b]  <= ~r_deb[b];
          r_dcnt[b] <= '0;
        end else begin
          r_dcnt[b] <= r_dcnt[b] + 8'(1);
        end
      end
    end
  end

  assign w_rise     = r_deb & ~r_deb_d;
  assign w_take_rst = (r_state == IDLE) && r_pend[1];
  assign w_take_set = (r_state == IDLE) && r_pend[0] && !r_pend[1];

  // A fresh rise re-arms a flag even on the edge it is consumed; repeats merge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~{w_take_rst, w_take_set}) | w_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cmd_rst <= 1'b0;
      r_pcnt    <= '0;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take_rst || w_take_set) begin
            r_state   <= DRIVE;
            r_cmd_rst <= w_take_rst;
            r_pcnt    <= '0;
            r_s       <= w_take_set;
            r_r       <= w_take_rst;
            r_busy    <= 1'b1;
          end
        end
        DRIVE: begin
          if (r_pcnt == PULSE_LAST) begin
            r_state <= CHECK;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt + 4'(1);
          end
        end
        CHECK: begin
          // Expected q is 1 after set and 0 after reset, i.e. the inverse of r_cmd_rst.
          if (q_fb == r_cmd_rst) r_err <= 1'b1;
          r_cnt   <= r_cnt + CNT_W'(1);
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s       = r_s;
  assign r       = r_r;
  assign busy    = r_busy;
  assign err     = r_err;
  assign cmd_cnt = r_cnt;
endmodule
